// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned UART_BYTE_W = 8;
    localparam int unsigned BURST_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_any,
    output logic [IDX_W-1:0] o_idx
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned w_pos;
        o_any = 1'b0;
        o_idx = '0;
        w_pos = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            if (!o_any && i_req[IDX_W'(w_pos)]) begin
                o_any = 1'b1;
                o_idx = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ byte-stream requesters with packet-granular
// round-robin grants, a burst cap and a mid-packet stall timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned MAX_BURST     = 16,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [N_REQ-1:0]             req_valid_in,
    input  logic [N_REQ*UART_BYTE_W-1:0] req_byte_in,
    input  logic [N_REQ-1:0]             req_last_in,
    output logic [N_REQ-1:0]             req_ready_out,
    output logic                         tx_valid_out,
    output logic [UART_BYTE_W-1:0]       tx_byte_out,
    input  logic                         tx_ready_in,
    output logic [N_REQ-1:0]             grant_out,
    output logic                         busy_out
);

    localparam int unsigned IDX_W   = $clog2(N_REQ);
    localparam int unsigned STALL_W = $clog2(STALL_TIMEOUT) + 1;

    arb_state_t             r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_gidx;
    logic [N_REQ-1:0]       r_grant;
    logic [UART_BYTE_W-1:0] r_byte;
    logic                   r_last;
    logic [BURST_W-1:0]     r_burst_cnt;
    logic [STALL_W-1:0]     r_stall_cnt;
    logic                   r_tx_valid;
    logic                   r_busy;

    logic                   w_any;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_load;
    logic                   w_accept;
    logic [UART_BYTE_W-1:0] w_byte_sel;
    logic                   w_last_sel;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req (req_valid_in),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_pick)
    );

    // Holder's byte lane and accept strobe; ready is only offered in LOAD.
    assign w_load        = (r_state == LOAD);
    assign w_byte_sel    = req_byte_in[32'(r_gidx) * UART_BYTE_W +: UART_BYTE_W];
    assign w_last_sel    = req_last_in[r_gidx];
    assign w_accept      = w_load && req_valid_in[r_gidx];
    assign req_ready_out = w_load ? (req_valid_in & r_grant) : '0;

    assign tx_valid_out  = r_tx_valid;
    assign tx_byte_out   = r_byte;
    assign grant_out     = r_grant;
    assign busy_out      = r_busy;

    // Arbitration FSM with its counters and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_grant     <= '0;
            r_byte      <= '0;
            r_last      <= 1'b0;
            r_burst_cnt <= '0;
            r_stall_cnt <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_stall_cnt <= '0;
                    if (w_any) begin
                        r_gidx      <= w_pick;
                        r_grant     <= N_REQ'(1) << w_pick;
                        r_burst_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_byte      <= w_byte_sel;
                        r_last      <= w_last_sel;
                        r_stall_cnt <= '0;
                        r_tx_valid  <= 1'b1;
                        r_state     <= ISSUE;
                        if (r_burst_cnt < BURST_W'(MAX_BURST)) begin
                            r_burst_cnt <= r_burst_cnt + BURST_W'(1);
                        end
                    end else begin
                        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
                        if (r_stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) begin
                            r_state <= RELEASE;
                        end
                    end
                end
                ISSUE: begin
                    if (tx_ready_in) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_ready_in) begin
                        r_state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_ready_in) begin
                        if (r_last || (r_burst_cnt == BURST_W'(MAX_BURST))) begin
                            r_state <= RELEASE;
                        end else begin
                            r_state <= LOAD;
                        end
                    end
                end
                RELEASE: begin
                    r_ptr   <= (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet mixes
// checked against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int ST = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_byte;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_byte;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;

    uart_tx_arbiter #(
        .N_REQ         (N),
        .MAX_BURST     (MB),
        .STALL_TIMEOUT (ST)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .req_valid_in  (req_valid),
        .req_byte_in   (req_byte),
        .req_last_in   (req_last),
        .req_ready_out (req_ready),
        .tx_valid_out  (tx_valid),
        .tx_byte_out   (tx_byte),
        .tx_ready_in   (tx_ready),
        .grant_out     (grant),
        .busy_out      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-requester pending bytes {last, byte}; transfer log {grant, byte}.
    logic [8:0]  q [N][$];
    logic [11:0] log_q [$];
    logic [11:0] exp_q [$];
    int          u_cnt;
    bit          u_idle;
    bit          hold;
    int          n_chk;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic drive();
        logic [8:0] e;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                e = q[i][0];
                req_valid[i]      = 1'b1;
                req_byte[i*8 +: 8] = e[7:0];
                req_last[i]       = e[8];
            end else begin
                req_valid[i]      = 1'b0;
                req_byte[i*8 +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        tx_ready = u_idle && !hold;
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        q[r].push_back({l, b});
        drive();
    endtask

    // One clock: sample handshakes mid-cycle, then update producers and uart model.
    task automatic tick();
        logic [N-1:0] acc;
        logic         xfer;
        logic [11:0]  ent;
        @(negedge clk);
        acc  = req_ready;
        xfer = tx_valid && tx_ready;
        ent  = {grant, tx_byte};
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        if (xfer) begin
            log_q.push_back(ent);
            u_idle = 1'b0;
            u_cnt  = 10;
        end else if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) u_idle = 1'b1;
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        hold   = 1'b0;
        for (int i = 0; i < N; i++) q[i].delete();
        log_q.delete();
        u_idle = 1'b1;
        u_cnt  = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) e = 1'b0;
        return e;
    endfunction

    task automatic run_idle(input string tag);
        int n = 0;
        while (!(all_empty() && !busy && u_idle) && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(n < 5000), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!tx_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid_seen"}, 32'(tx_valid), 32'd1);
    endtask

    // Transaction model: from pointer 0, serve the first non-empty queue at or
    // after the pointer for up to MB bytes, stopping after a last byte or when
    // the queue runs dry; the pointer then moves past the served requester.
    task automatic build_model();
        logic [8:0]   m [N][$];
        logic [8:0]   e;
        logic [N-1:0] oh;
        int           p;
        int           g;
        int           n;
        bit           done;
        exp_q.delete();
        for (int i = 0; i < N; i++) m[i] = q[i];
        p = 0;
        forever begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m[(p + k) % N].size() > 0) g = (p + k) % N;
            end
            if (g < 0) break;
            oh    = '0;
            oh[g] = 1'b1;
            n     = 0;
            done  = 1'b0;
            while (!done) begin
                e = m[g].pop_front();
                exp_q.push_back({oh, e[7:0]});
                n++;
                if (e[8] || n == MB || m[g].size() == 0) done = 1'b1;
            end
            p = (g + 1) % N;
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int np;
        int len;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        hold   = 1'b0;
        u_idle = 1'b1;
        u_cnt  = 0;
        drive();

        // Reset values, with a request already pending.
        push(2, 8'h5A, 1'b1);
        #12;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        do_reset();

        // Single packet from requester 0.
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h43, 1'b1);
        tick();
        check("single_grant_early", 32'(grant), 32'h1);
        run_idle("single");
        exp_q = '{12'h141, 12'h142, 12'h143};
        compare_log("single");
        check("single_idle_grant", 32'(grant), 32'd0);
        // Pointer now at 1: requester 1 beats requester 0.
        log_q.delete();
        push(0, 8'h10, 1'b1);
        push(1, 8'h11, 1'b1);
        run_idle("ptr1");
        exp_q = '{12'h211, 12'h110};
        compare_log("ptr1");

        // Round-robin with 1-byte packets from all requesters.
        do_reset();
        for (int i = 0; i < N; i++) begin
            push(i, 8'hC0 + 8'(i), 1'b1);
            push(i, 8'hD0 + 8'(i), 1'b1);
        end
        build_model();
        run_idle("rr");
        compare_log("rr");
        for (int k = 0; k < 5 && k < log_q.size(); k++) begin
            check($sformatf("rr_order%0d", k), 32'(log_q[k][11:8]), 32'(1 << (k % N)));
        end

        // Burst cap: requester 1 streams 10 bytes without last, requester 2 waits.
        do_reset();
        for (int b = 1; b <= 10; b++) push(1, 8'(b), 1'b0);
        push(2, 8'hB1, 1'b0);
        push(2, 8'hB2, 1'b1);
        build_model();
        run_idle("burst");
        compare_log("burst");
        if (log_q.size() > 6) begin
            check("burst_req2_after4", 32'(log_q[4]), 32'h4B1);
            check("burst_resume5", 32'(log_q[6]), 32'h205);
        end else begin
            check("burst_len_min", 32'(log_q.size()), 32'd7);
        end

        // Stall: requester 0 stops mid-packet, requester 3 waits.
        do_reset();
        push(0, 8'h55, 1'b0);
        n = 0;
        while (log_q.size() < 1 && n < 200) begin tick(); n++; end
        check("stall_first_xfer", 32'(log_q.size()), 32'd1);
        push(3, 8'h33, 1'b1);
        n = 0;
        while (!tx_ready && n < 100) begin tick(); n++; end
        check("stall_grant_held", 32'(grant), 32'h1);
        tick();
        check("stall_no_ready", 32'(req_ready), 32'd0);
        n = 1;
        while (grant != '0 && n < 40) begin tick(); n++; end
        check("stall_release_cycles", 32'(n), 32'd10);
        run_idle("stall");
        exp_q = '{12'h155, 12'h833};
        compare_log("stall");

        // Reset during ISSUE with the pointer moved away from 0.
        do_reset();
        push(2, 8'hA1, 1'b1);
        run_idle("mr_pre");
        log_q.delete();
        hold = 1'b1;
        push(2, 8'hA2, 1'b0);
        push(2, 8'hA3, 1'b1);
        wait_valid("mr");
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_tx_valid", 32'(tx_valid), 32'd0);
        check("mr_grant", 32'(grant), 32'd0);
        check("mr_ready", 32'(req_ready), 32'd0);
        check("mr_tx_byte", 32'(tx_byte), 32'd0);
        do_reset();
        check("mr_idle", 32'(busy), 32'd0);
        push(3, 8'h3F, 1'b1);
        push(0, 8'h0F, 1'b1);
        run_idle("mr_post");
        exp_q = '{12'h10F, 12'h83F};
        compare_log("mr_post");

        // Handshake: uart_tx not ready while the byte is presented.
        do_reset();
        hold = 1'b1;
        push(1, 8'hAA, 1'b1);
        wait_valid("hs");
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hs_valid%0d", k), 32'(tx_valid), 32'd1);
            check($sformatf("hs_byte%0d", k), 32'(tx_byte), 32'hAA);
        end
        check("hs_no_xfer", 32'(log_q.size()), 32'd0);
        hold = 1'b0;
        drive();
        run_idle("hs");
        exp_q = '{12'h2AA};
        compare_log("hs");

        // Randomized packet mixes.
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 7);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
                end
            end
            build_model();
            run_idle($sformatf("rand%0d", r));
            compare_log($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
